// File: rtl/axi_pkg.sv
// Shared AXI constants and the state encodings used by the memory responder.
package axi_pkg;

  localparam logic [2:0] RespOkay   = 3'd0;
  localparam logic [2:0] RespSlverr = 3'd2;
  localparam logic [2:0] RespDecerr = 3'd3;

  localparam logic [1:0] BurstFixed = 2'd0;
  localparam logic [1:0] BurstIncr  = 2'd1;
  localparam logic [1:0] BurstWrap  = 2'd2;

  localparam int unsigned IdWDefault = 3;

  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  typedef enum logic       {RIdle, RData} r_state_e;

  // Only FIXED and INCR are served; WRAP and the reserved code are rejected.
  function automatic logic burst_supported(logic [1:0] burst);
    return (burst == BurstFixed) || (burst == BurstIncr);
  endfunction

endpackage

// File: rtl/axi_addr_gen.sv
// Beat address stepping and word-index/range decode for one AXI channel.
module axi_addr_gen import axi_pkg::*; #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       DEPTH     = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       IDX_W     = 10
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [1:0]        burst_i,
  output logic [ADDR_W-1:0] next_addr_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic              decerr_o
);

  localparam int unsigned AddrLsb = $clog2(DATA_W / 8);

  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] word;

  // Index decode ignores unaligned low bits; anything outside the array is DECERR.
  always_comb begin
    offset      = addr_i - BASE_ADDR;
    word        = offset >> AddrLsb;
    decerr_o    = (addr_i < BASE_ADDR) || (word >= ADDR_W'(DEPTH));
    idx_o       = word[IDX_W-1:0];
    next_addr_o = (burst_i == BurstIncr) ? addr_i + ADDR_W'(DATA_W / 8) : addr_i;
  end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI memory responder: independent write (AW/W/B) and read (AR/R) engines over
// a word-organised register array with byte strobes.
module axi_mem_slave import axi_pkg::*; #(
  parameter int unsigned       ID_W      = IdWDefault,
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       LEN_W     = 8,
  parameter int unsigned       SIZE_W    = 3,
  parameter int unsigned       DEPTH     = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [LEN_W-1:0]    awlen,
  input  logic [SIZE_W-1:0]   awsize,
  input  logic [1:0]          awburst,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [ID_W-1:0]     bid,
  output logic [2:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [ID_W-1:0]     arid,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [LEN_W-1:0]    arlen,
  input  logic [SIZE_W-1:0]   arsize,
  input  logic [1:0]          arburst,
  input  logic                arvalid,
  output logic                arready,
  output logic [ID_W-1:0]     rid,
  output logic [DATA_W-1:0]   rdata,
  output logic [2:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready
);

  localparam int unsigned       StrbW    = DATA_W / 8;
  localparam int unsigned       IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SIZE_W-1:0] FullSize = SIZE_W'($clog2(StrbW));

  logic [DATA_W-1:0] mem [DEPTH];

  // Held low through reset so awready/arready only rise once reset is released.
  logic live_q, live_d;

  // Write path state.
  w_state_e          w_state_q, w_state_d;
  logic [ID_W-1:0]   w_id_q, w_id_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [LEN_W-1:0]  w_len_q, w_len_d;
  logic [1:0]        w_burst_q, w_burst_d;
  logic [LEN_W:0]    w_cnt_q, w_cnt_d;
  logic              w_slv_q, w_slv_d;
  logic              w_dec_q, w_dec_d;
  logic [2:0]        bresp_q, bresp_d;
  logic [ADDR_W-1:0] w_next_addr;
  logic [IdxW-1:0]   w_idx;
  logic              w_decerr;
  logic              w_in_range;
  logic              mem_we;

  // Read path state.
  r_state_e          r_state_q, r_state_d;
  logic [ID_W-1:0]   r_id_q, r_id_d;
  logic [ADDR_W-1:0] r_addr_q, r_addr_d;
  logic [LEN_W-1:0]  r_len_q, r_len_d;
  logic [1:0]        r_burst_q, r_burst_d;
  logic [LEN_W-1:0]  r_cnt_q, r_cnt_d;
  logic              r_slv_q, r_slv_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [2:0]        rresp_q, rresp_d;
  logic              rlast_q, rlast_d;
  logic [ADDR_W-1:0] r_addr_in;
  logic [1:0]        r_burst_in;
  logic [ADDR_W-1:0] r_next_addr;
  logic [IdxW-1:0]   r_idx;
  logic              r_decerr;
  logic              beat_slv;
  logic [DATA_W-1:0] beat_data;
  logic [2:0]        beat_resp;

  axi_addr_gen #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE_ADDR),
    .IDX_W     (IdxW)
  ) u_w_addr_gen (
    .addr_i      (w_addr_q),
    .burst_i     (w_burst_q),
    .next_addr_o (w_next_addr),
    .idx_o       (w_idx),
    .decerr_o    (w_decerr)
  );

  // While idle the read decoder looks at the incoming AR so beat 0 loads on the handshake.
  assign r_addr_in  = (r_state_q == RIdle) ? araddr : r_addr_q;
  assign r_burst_in = (r_state_q == RIdle) ? arburst : r_burst_q;

  axi_addr_gen #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE_ADDR),
    .IDX_W     (IdxW)
  ) u_r_addr_gen (
    .addr_i      (r_addr_in),
    .burst_i     (r_burst_in),
    .next_addr_o (r_next_addr),
    .idx_o       (r_idx),
    .decerr_o    (r_decerr)
  );

  assign live_d = 1'b1;

  // Write FSM: accept AW, absorb W beats, report the accumulated response on B.
  always_comb begin
    w_state_d  = w_state_q;
    w_id_d     = w_id_q;
    w_addr_d   = w_addr_q;
    w_len_d    = w_len_q;
    w_burst_d  = w_burst_q;
    w_cnt_d    = w_cnt_q;
    w_slv_d    = w_slv_q;
    w_dec_d    = w_dec_q;
    bresp_d    = bresp_q;
    mem_we     = 1'b0;
    w_in_range = (w_cnt_q <= {1'b0, w_len_q});
    unique case (w_state_q)
      WIdle: begin
        if (live_q && awvalid) begin
          w_state_d = WData;
          w_id_d    = awid;
          w_addr_d  = awaddr;
          w_len_d   = awlen;
          w_burst_d = awburst;
          w_cnt_d   = '0;
          w_slv_d   = !burst_supported(awburst) || (awsize != FullSize);
          w_dec_d   = 1'b0;
        end
      end
      WData: begin
        if (wvalid) begin
          // Excess beats past awlen+1 are swallowed without touching memory.
          if (w_in_range && !w_slv_q) begin
            if (w_decerr) w_dec_d = 1'b1;
            else          mem_we  = !rst_i;
          end
          w_addr_d = w_next_addr;
          if (w_cnt_q != '1) w_cnt_d = w_cnt_q + 1'b1;
          if (wlast) begin
            w_state_d = WResp;
            if (w_slv_q || (w_cnt_q != {1'b0, w_len_q})) bresp_d = RespSlverr;
            else if (w_dec_d)                            bresp_d = RespDecerr;
            else                                         bresp_d = RespOkay;
          end
        end
      end
      WResp: begin
        if (bready) w_state_d = WIdle;
      end
      default: w_state_d = WIdle;
    endcase
  end

  // Read beat contents: errors force zero data.
  always_comb begin
    beat_slv = (r_state_q == RIdle) ? (!burst_supported(arburst) || (arsize != FullSize))
                                    : r_slv_q;
    if (beat_slv) begin
      beat_data = '0;
      beat_resp = RespSlverr;
    end else if (r_decerr) begin
      beat_data = '0;
      beat_resp = RespDecerr;
    end else begin
      beat_data = mem[r_idx];
      beat_resp = RespOkay;
    end
  end

  // Read FSM: load beat 0 on AR, then one beat per R handshake until rlast.
  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_burst_d = r_burst_q;
    r_cnt_d   = r_cnt_q;
    r_slv_d   = r_slv_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    unique case (r_state_q)
      RIdle: begin
        if (live_q && arvalid) begin
          r_state_d = RData;
          r_id_d    = arid;
          r_len_d   = arlen;
          r_burst_d = arburst;
          r_cnt_d   = '0;
          r_slv_d   = beat_slv;
          r_addr_d  = r_next_addr;
          rlast_d   = (arlen == '0);
          rdata_d   = beat_data;
          rresp_d   = beat_resp;
        end
      end
      RData: begin
        if (rready) begin
          if (rlast_q) begin
            r_state_d = RIdle;
            rlast_d   = 1'b0;
          end else begin
            r_cnt_d  = r_cnt_q + 1'b1;
            rlast_d  = (r_cnt_d == r_len_q);
            r_addr_d = r_next_addr;
            rdata_d  = beat_data;
            rresp_d  = beat_resp;
          end
        end
      end
      default: r_state_d = RIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      live_q    <= 1'b0;
      w_state_q <= WIdle;
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_burst_q <= BurstFixed;
      w_cnt_q   <= '0;
      w_slv_q   <= 1'b0;
      w_dec_q   <= 1'b0;
      bresp_q   <= RespOkay;
      r_state_q <= RIdle;
      r_id_q    <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_burst_q <= BurstFixed;
      r_cnt_q   <= '0;
      r_slv_q   <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RespOkay;
      rlast_q   <= 1'b0;
    end else begin
      live_q    <= live_d;
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_burst_q <= w_burst_d;
      w_cnt_q   <= w_cnt_d;
      w_slv_q   <= w_slv_d;
      w_dec_q   <= w_dec_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_burst_q <= r_burst_d;
      r_cnt_q   <= r_cnt_d;
      r_slv_q   <= r_slv_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
    end
  end

  // Storage array: byte-lane writes, never cleared by reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < StrbW; b++) begin
        if (wstrb[b]) mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign awready = live_q && (w_state_q == WIdle);
  assign wready  = (w_state_q == WData);
  assign bvalid  = (w_state_q == WResp);
  assign bid     = w_id_q;
  assign bresp   = bresp_q;
  assign arready = live_q && (r_state_q == RIdle);
  assign rvalid  = (r_state_q == RData);
  assign rid     = r_id_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign rlast   = rlast_q;

endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed bench for axi_mem_slave with hand-computed expectations.
module tb_axi_mem_slave;

  localparam int unsigned ID_W = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  awid = '0, arid = '0;
  logic [31:0] awaddr = '0, araddr = '0;
  logic [7:0]  awlen = '0, arlen = '0;
  logic [2:0]  awsize = '0, arsize = '0;
  logic [1:0]  awburst = '0, arburst = '0;
  logic        awvalid = 1'b0, arvalid = 1'b0;
  logic        awready, arready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0, wvalid = 1'b0, wready;
  logic [2:0]  bid, rid;
  logic [2:0]  bresp, rresp;
  logic        bvalid, bready = 1'b0;
  logic [31:0] rdata;
  logic        rlast, rvalid, rready = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [31:0] wd [8];
  logic [3:0]  ws [8];
  logic [31:0] ed [8];
  logic [2:0]  er [8];

  axi_mem_slave #(.ID_W(ID_W)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .awid    (awid),
    .awaddr  (awaddr),
    .awlen   (awlen),
    .awsize  (awsize),
    .awburst (awburst),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wlast   (wlast),
    .wvalid  (wvalid),
    .wready  (wready),
    .bid     (bid),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready),
    .arid    (arid),
    .araddr  (araddr),
    .arlen   (arlen),
    .arsize  (arsize),
    .arburst (arburst),
    .arvalid (arvalid),
    .arready (arready),
    .rid     (rid),
    .rdata   (rdata),
    .rresp   (rresp),
    .rlast   (rlast),
    .rvalid  (rvalid),
    .rready  (rready)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_awready"}, awready, 1'b0);
    check({tag, "_arready"}, arready, 1'b0);
    check({tag, "_wready"}, wready, 1'b0);
    check({tag, "_bvalid"}, bvalid, 1'b0);
    check({tag, "_rvalid"}, rvalid, 1'b0);
    check({tag, "_rlast"}, rlast, 1'b0);
    check({tag, "_bid"}, bid, 3'd0);
    check({tag, "_rid"}, rid, 3'd0);
    check({tag, "_bresp"}, bresp, 3'd0);
    check({tag, "_rresp"}, rresp, 3'd0);
    check({tag, "_rdata"}, rdata, 32'd0);
  endtask

  task automatic send_aw(input logic [2:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [2:0] size);
    int n = 0;
    awid = id; awaddr = addr; awlen = len; awburst = burst; awsize = size; awvalid = 1'b1;
    while (!awready && n < 20) begin tick(); n++; end
    check("aw_accept", awready, 1'b1);
    tick();
    awvalid = 1'b0;
    check("wready_lat", wready, 1'b1);
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int n = 0;
    wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
    while (!wready && n < 20) begin tick(); n++; end
    check("w_accept", wready, 1'b1);
    tick();
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic write_burst(input string tag, input logic [2:0] id, input logic [31:0] addr,
                             input logic [7:0] len, input logic [1:0] burst,
                             input logic [2:0] size, input int nbeats, input int stall,
                             input logic [2:0] exp_resp);
    send_aw(id, addr, len, burst, size);
    for (int i = 0; i < nbeats; i++) send_w(wd[i], ws[i], i == nbeats - 1);
    check({tag, "_bvalid"}, bvalid, 1'b1);
    for (int s = 0; s < stall; s++) begin
      tick();
      check({tag, "_bhold"}, bvalid, 1'b1);
    end
    check({tag, "_bresp"}, bresp, exp_resp);
    check({tag, "_bid"}, bid, id);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check({tag, "_bdone"}, bvalid, 1'b0);
  endtask

  task automatic read_burst(input string tag, input logic [2:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [1:0] burst,
                            input int stall_beat, input int stall_n);
    int n = 0;
    arid = id; araddr = addr; arlen = len; arburst = burst; arsize = 3'd2; arvalid = 1'b1;
    while (!arready && n < 20) begin tick(); n++; end
    check({tag, "_ar_accept"}, arready, 1'b1);
    tick();
    arvalid = 1'b0;
    check({tag, "_rvalid_lat"}, rvalid, 1'b1);
    for (int i = 0; i <= int'(len); i++) begin
      if (i == stall_beat) begin
        for (int s = 0; s < stall_n; s++) begin
          tick();
          check($sformatf("%s_hold%0d_v", tag, s), rvalid, 1'b1);
          check($sformatf("%s_hold%0d_d", tag, s), rdata, ed[i]);
        end
      end
      check($sformatf("%s_b%0d_valid", tag, i), rvalid, 1'b1);
      check($sformatf("%s_b%0d_data", tag, i), rdata, ed[i]);
      check($sformatf("%s_b%0d_resp", tag, i), rresp, er[i]);
      check($sformatf("%s_b%0d_last", tag, i), rlast, i == int'(len));
      check($sformatf("%s_b%0d_id", tag, i), rid, id);
      rready = 1'b1;
      tick();
      rready = 1'b0;
    end
    check({tag, "_rdone"}, rvalid, 1'b0);
  endtask

  initial begin
    // Reset and release.
    repeat (3) tick();
    check_reset_outs("rst");
    rst = 1'b0;
    tick();
    check("rel_awready", awready, 1'b1);
    check("rel_arready", arready, 1'b1);

    // Single write then read.
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    write_burst("w1", 3'd5, 32'h10, 8'd0, 2'd1, 3'd2, 1, 0, 3'd0);
    ed[0] = 32'hDEADBEEF; er[0] = 3'd0;
    read_burst("r1", 3'd3, 32'h10, 8'd0, 2'd1, -1, 0);

    // INCR burst with a partial strobe on beat 2, B and R backpressure.
    wd[0] = 32'hAABBCCDD; ws[0] = 4'hF;
    write_burst("wpre", 3'd0, 32'h28, 8'd0, 2'd1, 3'd2, 1, 0, 3'd0);
    wd[0] = 32'd1; wd[1] = 32'd2; wd[2] = 32'd3; wd[3] = 32'd4;
    ws[0] = 4'hF;  ws[1] = 4'hF;  ws[2] = 4'h3;  ws[3] = 4'hF;
    write_burst("w2", 3'd1, 32'h20, 8'd3, 2'd1, 3'd2, 4, 2, 3'd0);
    ed[0] = 32'd1; ed[1] = 32'd2; ed[2] = 32'hAABB0003; ed[3] = 32'd4;
    er[0] = 3'd0;  er[1] = 3'd0;  er[2] = 3'd0;         er[3] = 3'd0;
    read_burst("r2", 3'd2, 32'h20, 8'd3, 2'd1, 1, 3);

    // Unsupported burst type and size: SLVERR, memory untouched.
    wd[0] = 32'h11111111; ws[0] = 4'hF;
    write_burst("wwrap", 3'd0, 32'h10, 8'd0, 2'd2, 3'd2, 1, 0, 3'd2);
    write_burst("wsize", 3'd0, 32'h10, 8'd0, 2'd1, 3'd1, 1, 0, 3'd2);
    ed[0] = 32'hDEADBEEF; er[0] = 3'd0;
    read_burst("r3", 3'd1, 32'h10, 8'd0, 2'd1, -1, 0);

    // Read running off the end of the array.
    wd[0] = 32'h12345678; ws[0] = 4'hF;
    write_burst("wlastw", 3'd0, 32'hFFC, 8'd0, 2'd1, 3'd2, 1, 0, 3'd0);
    ed[0] = 32'h12345678; ed[1] = 32'd0; er[0] = 3'd0; er[1] = 3'd3;
    read_burst("r4", 3'd4, 32'hFFC, 8'd1, 2'd1, -1, 0);

    // Out-of-range write and early wlast.
    write_burst("wdec", 3'd2, 32'h1000, 8'd0, 2'd1, 3'd2, 1, 0, 3'd3);
    wd[0] = 32'hA; wd[1] = 32'hB; ws[0] = 4'hF; ws[1] = 4'hF;
    write_burst("wshort", 3'd3, 32'h40, 8'd3, 2'd1, 3'd2, 2, 0, 3'd2);

    // Same-word write and read in the same cycle: read sees old data.
    send_aw(3'd6, 32'h10, 8'd0, 2'd1, 3'd2);
    wdata = 32'hCAFEF00D; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    arid = 3'd7; araddr = 32'h10; arlen = 8'd0; arburst = 2'd1; arsize = 3'd2; arvalid = 1'b1;
    check("cc_arready", arready, 1'b1);
    tick();
    wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
    check("cc_rvalid", rvalid, 1'b1);
    check("cc_rdata_old", rdata, 32'hDEADBEEF);
    check("cc_bvalid", bvalid, 1'b1);
    check("cc_bresp", bresp, 3'd0);
    rready = 1'b1; bready = 1'b1;
    tick();
    rready = 1'b0; bready = 1'b0;
    ed[0] = 32'hCAFEF00D; er[0] = 3'd0;
    read_burst("r5", 3'd0, 32'h10, 8'd0, 2'd1, -1, 0);

    // Reset during beat 2 of a 4-beat write.
    send_aw(3'd2, 32'h80, 8'd3, 2'd1, 3'd2);
    send_w(32'h100, 4'hF, 1'b0);
    send_w(32'h101, 4'hF, 1'b0);
    wdata = 32'h102; wstrb = 4'hF; wvalid = 1'b1;
    rst = 1'b1;
    tick();
    check_reset_outs("mid");
    rst = 1'b0; wvalid = 1'b0;
    tick();
    check("mid_rel_awready", awready, 1'b1);
    ed[0] = 32'h100; ed[1] = 32'h101; er[0] = 3'd0; er[1] = 3'd0;
    read_burst("r6", 3'd1, 32'h80, 8'd1, 2'd1, -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
